// File: rtl/flash_arbiter.sv
// ---------------------------------------------------------------------------
// flash_arbiter
//
// Two-requester round-robin arbiter and sequencer in front of the 8-bit
// StrataFlash bridge. It grants the bridge to client A or B and issues one
// start strobe with the granted request's fields latched. It then waits for
// the bridge's completion and returns read data and status to the granted
// client with a one-cycle acknowledge.
//
// Optional feature macro: FLASH_ARB_TIMEOUT_EN
//   defined   - WAIT aborts after TIMEOUT_CYCLES cycles without br_done
//               (br_abort pulse, err = 1, rd_data = 0x00, ack still issued)
//   undefined - WAIT holds until br_done; err and br_abort are tied to 0
//
// Parameters:
//   TIMEOUT_CYCLES   WAIT cycles allowed before abort (1..255)
//
// Ports:
//   CLK_50MHZ                     system clock (only clock)
//   RST                           synchronous active-high reset
//   a_req/a_rw/a_addr/a_wdata     requester A request (rw: 1 = read)
//   a_ack                         one-cycle completion pulse to A
//   b_req/b_rw/b_addr/b_wdata     requester B request
//   b_ack                         one-cycle completion pulse to B
//   rd_data                       read result, held until the next ack
//   err                           timeout flag, valid in the ack cycle
//   owner                         current/last grant (0 = A, 1 = B)
//   busy                          high in every state except IDLE
//   br_start                      one-cycle start strobe to the bridge
//   br_rw/br_addr/br_wdata        latched request fields to the bridge
//   br_done/br_rdata              bridge completion and read data
//   br_abort                      one-cycle abort strobe on timeout
// ---------------------------------------------------------------------------
module flash_arbiter #(
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       a_req,
    input  logic       a_rw,
    input  logic [7:0] a_addr,
    input  logic [7:0] a_wdata,
    output logic       a_ack,
    input  logic       b_req,
    input  logic       b_rw,
    input  logic [7:0] b_addr,
    input  logic [7:0] b_wdata,
    output logic       b_ack,
    output logic [7:0] rd_data,
    output logic       err,
    output logic       owner,
    output logic       busy,
    output logic       br_start,
    output logic       br_rw,
    output logic [7:0] br_addr,
    output logic [7:0] br_wdata,
    input  logic       br_done,
    input  logic [7:0] br_rdata,
    output logic       br_abort
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } arbState_t;

    arbState_t  r_state;
    arbState_t  w_nextState;

    logic       r_owner;
    logic       r_aAck;
    logic       r_bAck;
    logic       r_brRw;
    logic [7:0] r_brAddr;
    logic [7:0] r_brWdata;
    logic [7:0] r_rdData;

    logic       w_aReq;
    logic       w_bReq;
    logic       w_anyReq;
    logic       w_grantB;
    logic       w_timeout;
    logic       w_busy;
    logic       w_brStart;

    // The ack is registered, so during the ack cycle the completed client
    // still holds req high. Masking it here keeps IDLE from re-granting a
    // request that has just been acknowledged.
    assign w_aReq   = a_req & ~r_aAck;
    assign w_bReq   = b_req & ~r_bAck;
    assign w_anyReq = w_aReq | w_bReq;

    // B wins when it is alone, or when both request and A was the last owner.
    assign w_grantB = w_bReq & (~w_aReq | ~r_owner);

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_count;
    logic       r_err;
    logic       r_abort;

    // The timeout fires on the WAIT edge at which the counter would reach
    // TIMEOUT_CYCLES; a br_done on that same edge takes priority.
    assign w_timeout = (r_state == ST_WAIT) && !br_done && (r_count == TIMEOUT_LAST);

    // Saturating count of WAIT cycles seen with br_done low.
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            r_count <= 8'h00;
        end else if (r_state == ST_ISSUE) begin
            r_count <= 8'h00;
        end else if ((r_state == ST_WAIT) && !br_done && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'h01;
        end
    end

    // Error flag and abort strobe for the timeout path.
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            r_err   <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            if (r_state == ST_WAIT) begin
                if (br_done) begin
                    r_err <= 1'b0;
                end else if (w_timeout) begin
                    r_err   <= 1'b1;
                    r_abort <= 1'b1;
                end
            end
        end
    end

    assign err      = r_err;
    assign br_abort = r_abort;
`else
    localparam int unusedTimeoutCycles = TIMEOUT_CYCLES;

    assign w_timeout = 1'b0;
    assign err       = 1'b0;
    assign br_abort  = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: grant, one issue cycle, wait for completion, ack.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (w_anyReq) w_nextState = ST_ISSUE;
            ST_ISSUE: w_nextState = ST_WAIT;
            ST_WAIT:  if (br_done || w_timeout) w_nextState = ST_DONE;
            ST_DONE:  w_nextState = ST_IDLE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    // Output decode: the start strobe is exactly the ISSUE cycle.
    always_comb begin
        w_busy    = 1'b1;
        w_brStart = 1'b0;
        case (r_state)
            ST_IDLE:  w_busy    = 1'b0;
            ST_ISSUE: w_brStart = 1'b1;
            default:  ;
        endcase
    end

    // Datapath: latch the winner's fields at the grant, capture the result
    // in WAIT, and pulse the owner's ack on leaving DONE.
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            r_owner   <= 1'b1;
            r_aAck    <= 1'b0;
            r_bAck    <= 1'b0;
            r_brRw    <= 1'b0;
            r_brAddr  <= 8'h00;
            r_brWdata <= 8'h00;
            r_rdData  <= 8'h00;
        end else begin
            r_aAck <= 1'b0;
            r_bAck <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_anyReq) begin
                        r_owner   <= w_grantB;
                        r_brRw    <= w_grantB ? b_rw    : a_rw;
                        r_brAddr  <= w_grantB ? b_addr  : a_addr;
                        r_brWdata <= w_grantB ? b_wdata : a_wdata;
                    end
                end
                ST_WAIT: begin
                    if (br_done) begin
                        if (r_brRw) r_rdData <= br_rdata;
                    end else if (w_timeout) begin
                        r_rdData <= 8'h00;
                    end
                end
                ST_DONE: begin
                    r_aAck <= ~r_owner;
                    r_bAck <= r_owner;
                end
                default: ;
            endcase
        end
    end

    assign a_ack    = r_aAck;
    assign b_ack    = r_bAck;
    assign rd_data  = r_rdData;
    assign owner    = r_owner;
    assign busy     = w_busy;
    assign br_start = w_brStart;
    assign br_rw    = r_brRw;
    assign br_addr  = r_brAddr;
    assign br_wdata = r_brWdata;

endmodule

// File: tb/tb_flash_arbiter.sv
// ---------------------------------------------------------------------------
// tb_flash_arbiter
//
// Randomized self-checking bench for flash_arbiter. Two client models raise
// requests at random and drop them after their ack; a bridge model answers
// with a random latency. A transaction-level reference model predicts the
// grant order, every output cycle by cycle, and the result data. Reset is
// occasionally forced in the middle of a WAIT.
// ---------------------------------------------------------------------------
module tb_flash_arbiter;

    localparam int TIMEOUT    = 10;
    localparam int NUM_CYCLES = 900;

    logic       CLK_50MHZ = 1'b0;
    logic       RST;
    logic       a_req, a_rw, b_req, b_rw;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_ack, b_ack;
    logic [7:0] rd_data;
    logic       err, owner, busy, br_start, br_rw, br_abort;
    logic [7:0] br_addr, br_wdata;
    logic       br_done;
    logic [7:0] br_rdata;

    flash_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .CLK_50MHZ(CLK_50MHZ),
        .RST      (RST),
        .a_req    (a_req),
        .a_rw     (a_rw),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_ack    (a_ack),
        .b_req    (b_req),
        .b_rw     (b_rw),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_ack    (b_ack),
        .rd_data  (rd_data),
        .err      (err),
        .owner    (owner),
        .busy     (busy),
        .br_start (br_start),
        .br_rw    (br_rw),
        .br_addr  (br_addr),
        .br_wdata (br_wdata),
        .br_done  (br_done),
        .br_rdata (br_rdata),
        .br_abort (br_abort)
    );

    // 50 MHz clock.
    always #10 CLK_50MHZ = ~CLK_50MHZ;

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 0;

    // Reference model of the current transaction: grant edge, edges from
    // grant to completion, winner, timeout flag, fields and bridge data.
    bit         mActive;
    int         mG, mL;
    bit         mWho, mTo, mOwner, mErr;
    logic       mRw;
    logic [7:0] mAddr, mWdata, mRdata, mRd;
    int         ackCycle;
    bit         ackWho;
    bit         rstWanted;

    // Client models.
    logic       cReq   [2];
    logic       cRw    [2];
    logic [7:0] cAddr  [2];
    logic [7:0] cWdata [2];
    int         dropAt [2];

    // Compare one observed value with its expectation.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s cycle %0d: observed 0x%02h, expected 0x%02h",
                     tag, cyc, observed, expected);
        end
    endtask

    // Apply the result of a completion that happened at the last edge.
    task automatic updateModel();
        if (mActive && cyc == mG + mL) begin
            if (mTo) begin
                mRd  = 8'h00;
                mErr = 1'b1;
            end else begin
                if (mRw) mRd = mRdata;
                mErr = 1'b0;
            end
        end
    endtask

    // Check every output for the current cycle against the model.
    task automatic checkCycle();
        logic expStart, expBusy, expAckA, expAckB, expAbort;
        expStart = mActive && (cyc == mG);
        expBusy  = mActive && (cyc >= mG) && (cyc <= mG + mL);
        expAckA  = (cyc == ackCycle) && !ackWho;
        expAckB  = (cyc == ackCycle) && ackWho;
        expAbort = mActive && mTo && (cyc == mG + mL);
        checkOutput("br_start", 8'(br_start), 8'(expStart));
        checkOutput("busy",     8'(busy),     8'(expBusy));
        checkOutput("a_ack",    8'(a_ack),    8'(expAckA));
        checkOutput("b_ack",    8'(b_ack),    8'(expAckB));
        checkOutput("owner",    8'(owner),    8'(mOwner));
        checkOutput("rd_data",  rd_data,      mRd);
        checkOutput("err",      8'(err),      8'(mErr));
        checkOutput("br_abort", 8'(br_abort), 8'(expAbort));
        checkOutput("br_rw",    8'(br_rw),    8'(mRw));
        checkOutput("br_addr",  br_addr,      mAddr);
        checkOutput("br_wdata", br_wdata,     mWdata);
        // A client drops req at the edge where it samples its ack.
        if (expAckA) dropAt[0] = cyc + 1;
        if (expAckB) dropAt[1] = cyc + 1;
    endtask

    // Decide all inputs for the next edge and advance the model.
    task automatic applyStimulus();
        bit rstNow, eA, eB, win;
        int r;
        rstNow = 1'b0;

        for (int x = 0; x < 2; x++) begin
            if (dropAt[x] == cyc) begin
                cReq[x]   = 1'b0;
                dropAt[x] = -1;
            end else if (!cReq[x] && $urandom_range(0, 2) == 0) begin
                cReq[x]   = 1'b1;
                cRw[x]    = 1'($urandom_range(0, 1));
                cAddr[x]  = 8'($urandom);
                cWdata[x] = 8'($urandom);
            end
        end

        if (cyc % 200 == 100) rstWanted = 1'b1;
        if (rstWanted && mActive && (cyc >= mG + 1) && (cyc + 1 < mG + mL)) begin
            rstNow    = 1'b1;
            rstWanted = 1'b0;
            mActive   = 1'b0;
            mOwner    = 1'b1;
            mRd       = 8'h00;
            mErr      = 1'b0;
            mRw       = 1'b0;
            mAddr     = 8'h00;
            mWdata    = 8'h00;
            ackCycle  = -10;
            for (int x = 0; x < 2; x++) begin
                cReq[x]   = 1'b0;
                dropAt[x] = -1;
            end
        end

        if (!rstNow && (!mActive || cyc + 1 >= mG + mL + 2)) begin
            eA = cReq[0] && !((cyc == ackCycle) && !ackWho);
            eB = cReq[1] && !((cyc == ackCycle) && ackWho);
            if (eA || eB) begin
                win     = (eA && eB) ? ~mOwner : eB;
                mWho    = win;
                mOwner  = win;
                mG      = cyc + 1;
                mRw     = cRw[win];
                mAddr   = cAddr[win];
                mWdata  = cWdata[win];
                mRdata  = 8'($urandom);
                mTo     = 1'b0;
`ifdef FLASH_ARB_TIMEOUT_EN
                r = $urandom_range(0, 3);
                if (r == 0) begin
                    mTo = 1'b1;
                    mL  = TIMEOUT + 1;
                end else if (r == 1) begin
                    mL  = TIMEOUT + 1;
                end else begin
                    mL  = $urandom_range(2, TIMEOUT);
                end
`else
                r  = 0;
                mL = $urandom_range(2, 6) + r;
`endif
                ackCycle = mG + mL + 1;
                ackWho   = win;
                mActive  = 1'b1;
            end
        end

        br_done  = 1'b0;
        br_rdata = 8'($urandom);
        if (!rstNow && mActive && !mTo && (cyc + 1 == mG + mL)) begin
            br_done  = 1'b1;
            br_rdata = mRdata;
        end else if (!rstNow && (!mActive || (cyc + 1 >= mG + mL + 1) || (cyc + 1 == mG))
                     && $urandom_range(0, 4) == 0) begin
            br_done = 1'b1;
        end

        RST     = rstNow;
        a_req   = cReq[0];
        a_rw    = cRw[0];
        a_addr  = cAddr[0];
        a_wdata = cWdata[0];
        b_req   = cReq[1];
        b_rw    = cRw[1];
        b_addr  = cAddr[1];
        b_wdata = cWdata[1];
    endtask

    // Main sequence: hold reset over the first edge, then run the random
    // traffic for a fixed number of cycles and print the summary.
    initial begin
        mActive   = 1'b0;
        mG        = 0;
        mL        = 0;
        mWho      = 1'b0;
        mTo       = 1'b0;
        mOwner    = 1'b1;
        mErr      = 1'b0;
        mRw       = 1'b0;
        mAddr     = 8'h00;
        mWdata    = 8'h00;
        mRdata    = 8'h00;
        mRd       = 8'h00;
        ackCycle  = -10;
        ackWho    = 1'b0;
        rstWanted = 1'b0;
        for (int x = 0; x < 2; x++) begin
            cReq[x]   = 1'b0;
            cRw[x]    = 1'b0;
            cAddr[x]  = 8'h00;
            cWdata[x] = 8'h00;
            dropAt[x] = -1;
        end
        RST      = 1'b1;
        a_req    = 1'b0;
        a_rw     = 1'b0;
        a_addr   = 8'h00;
        a_wdata  = 8'h00;
        b_req    = 1'b0;
        b_rw     = 1'b0;
        b_addr   = 8'h00;
        b_wdata  = 8'h00;
        br_done  = 1'b0;
        br_rdata = 8'h00;

        $display("[TB] starting flash_arbiter random run, %0d cycles", NUM_CYCLES);
        for (int i = 0; i < NUM_CYCLES; i++) begin
            @(posedge CLK_50MHZ);
            cyc++;
            @(negedge CLK_50MHZ);
            updateModel();
            checkCycle();
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
